// File: rtl/dp_ram_pkg.sv
// Shared definitions for masters of the dual-port synchronous RAM: FSM states and
// the active-low strobe encodings, ordered {cs_n, we_n, oe_n}.
package dp_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        RSP
    } state_t;

    localparam logic [2:0] STB_IDLE  = 3'b111;
    localparam logic [2:0] STB_WRITE = 3'b001;
    localparam logic [2:0] STB_READ  = 3'b010;

endpackage

// File: rtl/dp_ram_port_master.sv
// Valid/ready command-to-RAM-strobe sequencer for one dual-port RAM port; read data comes back on a response stream.
// Optional multi-beat reads with address wrap are enabled by defining DP_RAM_MASTER_BURST_EN.
module dp_ram_port_master
    import dp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
`ifdef DP_RAM_MASTER_BURST_EN
    input  logic [LEN_WIDTH-1:0]  cmd_len,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  ram_cs_n,
    output logic                  ram_we_n,
    output logic                  ram_oe_n,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_t                state, state_nxt;
    logic [2:0]            stb, stb_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_data_nxt;
`ifdef DP_RAM_MASTER_BURST_EN
    logic [LEN_WIDTH-1:0]  beats_left, beats_left_nxt;
`endif

    // Ready is masked during reset so a held command is never seen as accepted.
    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);
    assign {ram_cs_n, ram_we_n, ram_oe_n} = stb;

    always_comb begin
        state_nxt      = state;
        stb_nxt        = stb;
        addr_nxt       = ram_addr;
        wdata_nxt      = ram_wdata;
        rsp_valid_nxt  = rsp_valid;
        rsp_data_nxt   = rsp_data;
`ifdef DP_RAM_MASTER_BURST_EN
        beats_left_nxt = beats_left;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_nxt = cmd_addr;
                    if (cmd_write) begin
                        state_nxt = WR;
                        stb_nxt   = STB_WRITE;
                        wdata_nxt = cmd_wdata;
                    end else begin
                        state_nxt = RD;
                        stb_nxt   = STB_READ;
`ifdef DP_RAM_MASTER_BURST_EN
                        beats_left_nxt = cmd_len;
`endif
                    end
                end
            end
            WR: begin
                stb_nxt   = STB_IDLE;
                state_nxt = IDLE;
            end
            RD: begin
                stb_nxt   = STB_IDLE;
                state_nxt = CAP;
            end
            CAP: begin
                rsp_data_nxt  = ram_rdata;
                rsp_valid_nxt = 1'b1;
                state_nxt     = RSP;
            end
            RSP: begin
                // Strobes are left untouched here; the RAM sees idle for the whole wait.
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
`ifdef DP_RAM_MASTER_BURST_EN
                    if (beats_left != '0) begin
                        beats_left_nxt = beats_left - LEN_WIDTH'(1);
                        addr_nxt       = ram_addr + ADDR_WIDTH'(1);
                        stb_nxt        = STB_READ;
                        state_nxt      = RD;
                    end
`endif
                end
            end
            default: begin
                stb_nxt   = STB_IDLE;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            stb        <= STB_IDLE;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
`ifdef DP_RAM_MASTER_BURST_EN
            beats_left <= '0;
`endif
        end else begin
            state      <= state_nxt;
            stb        <= stb_nxt;
            ram_addr   <= addr_nxt;
            ram_wdata  <= wdata_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_data   <= rsp_data_nxt;
`ifdef DP_RAM_MASTER_BURST_EN
            beats_left <= beats_left_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_dp_ram_port_master.sv
// Directed bench for dp_ram_port_master driving a behavioural model of one dp_sync_ram port.
module tb_dp_ram_port_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
`ifdef DP_RAM_MASTER_BURST_EN
    logic [3:0]  cmd_len = 4'd0;
`endif
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        busy;
    logic        ram_cs_n, ram_we_n, ram_oe_n;
    logic [3:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dp_ram_port_master #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LEN_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef DP_RAM_MASTER_BURST_EN
        .cmd_len(cmd_len),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy),
        .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // One synchronous RAM port: write on the edge, registered read data after the edge.
    logic [15:0] mem [16];
    always @(posedge clk) begin
        if (!ram_cs_n && !ram_we_n) mem[ram_addr] <= ram_wdata;
        if (!ram_cs_n && !ram_oe_n) ram_rdata <= mem[ram_addr];
    end

    int rsp_count = 0;
    always @(posedge clk) if (rsp_valid && rsp_ready) rsp_count++;

    int  cyc = 0;
    always @(posedge clk) cyc++;

    logic [2:0] strobes;
    assign strobes = {ram_cs_n, ram_we_n, ram_oe_n};
    int bad_strobes = 0;
    always @(negedge clk) begin
        assert (strobes inside {3'b111, 3'b001, 3'b010});
        if (!(strobes inside {3'b111, 3'b001, 3'b010})) bad_strobes++;
    end

    bit mon_en = 1'b0;
    int wr_pulses = 0, gap_bad = 0, last_wr = -1;
    always @(negedge clk) begin
        if (mon_en && strobes == 3'b001) begin
            wr_pulses++;
            if (last_wr >= 0 && cyc - last_wr != 2) gap_bad++;
            last_wr = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after the accept edge.
    task automatic send(input logic wr, input logic [3:0] a, input logic [15:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Single read with rsp_ready high: valid is high after the second edge following accept.
    task automatic rd_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
        send(1'b0, a, 16'h0);
        @(negedge clk); check({tag, "_rd_vld0"}, 32'(rsp_valid), 32'd0);
        @(negedge clk); check({tag, "_cap_vld0"}, 32'(rsp_valid), 32'd0);
        @(negedge clk); check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, 32'(rsp_data), 32'(exp));
        @(negedge clk); check({tag, "_vld_clr"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 16'h0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_strobes", 32'(strobes), 32'h7);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        reset = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        send(1'b1, 4'h3, 16'hBEEF);
        check("wr_strobes", 32'(strobes), 32'h1);
        check("wr_addr", 32'(ram_addr), 32'h3);
        check("wr_data", 32'(ram_wdata), 32'hBEEF);
        check("wr_busy", 32'(busy), 32'd1);
        @(negedge clk); @(negedge clk);
        check("wr_done_strobes", 32'(strobes), 32'h7);
        c0 = rsp_count;
        rd_check("rd3", 4'h3, 16'hBEEF);
        check("rd3_one_rsp", 32'(rsp_count - c0), 32'd1);

        // Backpressure: response must sit still with RAM idle and no new command taken.
        rsp_ready = 1'b0;
        c0 = rsp_count;
        send(1'b0, 4'h3, 16'h0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'hBEEF);
            check("bp_ready", 32'(cmd_ready), 32'd0);
            check("bp_strobes", 32'(strobes), 32'h7);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake", 32'(rsp_count - c0), 32'd1);
        check("bp_vld_clr", 32'(rsp_valid), 32'd0);
        check("bp_idle", 32'(busy), 32'd0);
        @(negedge clk); @(negedge clk);
        check("bp_single_rsp", 32'(rsp_count - c0), 32'd1);

        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 16'h1000 + 16'(i));
        @(negedge clk); @(negedge clk);
        mon_en = 1'b0;
        check("stream_pulses", 32'(wr_pulses), 32'd16);
        check("stream_gap", 32'(gap_bad), 32'd0);
        rd_check("rdA", 4'hA, 16'h100A);
        rd_check("rdF", 4'hF, 16'h100F);

        // Reset while capturing, then while holding a response.
        send(1'b0, 4'h5, 16'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rstcap_vld", 32'(rsp_valid), 32'd0);
        check("rstcap_strobes", 32'(strobes), 32'h7);
        check("rstcap_busy", 32'(busy), 32'd0);
        @(negedge clk); reset = 1'b0;
        c0 = rsp_count;
        repeat (6) @(negedge clk);
        check("rstcap_no_rsp", 32'(rsp_count - c0), 32'd0);
        check("rstcap_vld_after", 32'(rsp_valid), 32'd0);

        rsp_ready = 1'b0;
        send(1'b0, 4'h3, 16'h0);
        repeat (3) @(negedge clk);
        check("rstrsp_pre_vld", 32'(rsp_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstrsp_vld", 32'(rsp_valid), 32'd0);
        check("rstrsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk); reset = 1'b0; rsp_ready = 1'b1;
        c0 = rsp_count;
        repeat (5) @(negedge clk);
        check("rstrsp_no_rsp", 32'(rsp_count - c0), 32'd0);
        check("rstrsp_ready", 32'(cmd_ready), 32'd1);

`ifdef DP_RAM_MASTER_BURST_EN
        begin
            logic [15:0] exp_seq [3];
            int got = 0, early_ready = 0, n = 0;
            exp_seq[0] = 16'd1; exp_seq[1] = 16'd2; exp_seq[2] = 16'd3;
            send(1'b1, 4'hE, 16'd1);
            send(1'b1, 4'hF, 16'd2);
            send(1'b1, 4'h0, 16'd3);
            cmd_len = 4'd2;
            send(1'b0, 4'hE, 16'h0);
            cmd_len = 4'd0;
            while (got < 3 && n < 60) begin
                @(negedge clk);
                n++;
                if (cmd_ready) early_ready++;
                if (rsp_valid) begin
                    check("burst_data", 32'(rsp_data), 32'(exp_seq[got]));
                    got++;
                end
            end
            check("burst_count", 32'(got), 32'd3);
            check("burst_no_early_ready", 32'(early_ready), 32'd0);
            @(negedge clk);
            check("burst_ready_after", 32'(cmd_ready), 32'd1);
        end
`endif

        check("strobe_legal", 32'(bad_strobes), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
